// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 binary-coded-modulation scan engine.
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_BLANK1,
    S_LATCH,
    S_BLANK2,
    S_DISPLAY
  } state_t;

  // Channel positions inside both the RAM word and hub_rgb: {R2,G2,B2,R1,G1,B1}
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned CH_B1  = 0;
  localparam int unsigned CH_G1  = 1;
  localparam int unsigned CH_R1  = 2;
  localparam int unsigned CH_B2  = 3;
  localparam int unsigned CH_G2  = 4;
  localparam int unsigned CH_R2  = 5;

endpackage

// File: rtl/hub75_plane_timer.sv
// On-time counter for one bit plane: loads brightness<<plane, counts down while lit.
module hub75_plane_timer #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned PBITS = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             run,
  input  logic [7:0]       bright,
  input  logic [PBITS-1:0] plane,
  output logic             zero,
  output logic             last
);

  localparam int unsigned TW = 8 + DEPTH - 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(bright) << plane;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);
  assign last = (cnt == TW'(1));

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75/HUB75E scan engine: fetches pixel words, shifts one bit plane per pass,
// latches the row and lights it for brightness<<plane cycles.
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int unsigned COLS     = 64,
  parameter int unsigned ROW_BITS = 5,
  parameter int unsigned DEPTH    = 5,
  parameter int unsigned BLANK    = 2,
  parameter int unsigned CBITS    = $clog2(COLS)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable,
  input  logic [7:0]                brightness,
  output logic                      ram_rd,
  output logic [ROW_BITS+CBITS-1:0] ram_addr,
  input  logic [6*DEPTH-1:0]        ram_rdata,
  output logic [5:0]                hub_rgb,
  output logic [ROW_BITS-1:0]       hub_row,
  output logic                      hub_ck,
  output logic                      hub_st,
  output logic                      hub_oe,
  output logic                      frame_start
);

  localparam int unsigned PBITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BBITS = $clog2(BLANK + 1);
  localparam int unsigned AW    = ROW_BITS + CBITS;

  state_t              state, state_n;
  logic [ROW_BITS-1:0] row, row_n;
  logic [PBITS-1:0]    plane, plane_n;
  logic [CBITS-1:0]    col, col_n;
  logic                ph, ph_n;
  logic [BBITS-1:0]    bcnt, bcnt_n;
  logic [7:0]          bright_q;
  logic                rd_q;
  logic                start, adv;
  logic                tmr_load, tmr_run, tmr_zero, tmr_last;
  logic                rd_n, ck_n, st_n, oe_n;
  logic [AW-1:0]       addr_n;
  logic [DEPTH-1:0]    ch_bits [NUM_CH];
  logic [5:0]          rgb_n;

  hub75_plane_timer #(
    .DEPTH (DEPTH),
    .PBITS (PBITS)
  ) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (tmr_load),
    .run    (tmr_run),
    .bright (bright_q),
    .plane  (plane),
    .zero   (tmr_zero),
    .last   (tmr_last)
  );

  assign ch_bits[CH_B1] = ram_rdata[CH_B1*DEPTH +: DEPTH];
  assign ch_bits[CH_G1] = ram_rdata[CH_G1*DEPTH +: DEPTH];
  assign ch_bits[CH_R1] = ram_rdata[CH_R1*DEPTH +: DEPTH];
  assign ch_bits[CH_B2] = ram_rdata[CH_B2*DEPTH +: DEPTH];
  assign ch_bits[CH_G2] = ram_rdata[CH_G2*DEPTH +: DEPTH];
  assign ch_bits[CH_R2] = ram_rdata[CH_R2*DEPTH +: DEPTH];

  always_comb begin
    rgb_n = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      rgb_n[ch] = ch_bits[ch][plane];
    end
  end

  always_comb begin
    state_n  = state;
    row_n    = row;
    plane_n  = plane;
    col_n    = col;
    ph_n     = ph;
    bcnt_n   = bcnt;
    start    = 1'b0;
    adv      = 1'b0;
    tmr_load = 1'b0;
    tmr_run  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_n = S_FETCH;
          ph_n    = 1'b0;
          start   = 1'b1;
        end
      end
      S_FETCH: begin
        if (!ph) begin
          ph_n = 1'b1;
        end else begin
          state_n = S_SHIFT;
          ph_n    = 1'b0;
          col_n   = '0;
        end
      end
      S_SHIFT: begin
        if (!ph) begin
          ph_n = 1'b1;
        end else begin
          ph_n = 1'b0;
          if (col == CBITS'(COLS - 1)) begin
            state_n = S_BLANK1;
            bcnt_n  = '0;
          end else begin
            col_n = col + CBITS'(1);
          end
        end
      end
      S_BLANK1: begin
        if (bcnt == BBITS'(BLANK - 1)) begin
          state_n = S_LATCH;
        end else begin
          bcnt_n = bcnt + BBITS'(1);
        end
      end
      S_LATCH: begin
        state_n  = S_BLANK2;
        bcnt_n   = '0;
        tmr_load = 1'b1;
      end
      S_BLANK2: begin
        if (bcnt == BBITS'(BLANK - 1)) begin
          if (tmr_zero) adv = 1'b1;
          else          state_n = S_DISPLAY;
        end else begin
          bcnt_n = bcnt + BBITS'(1);
        end
      end
      S_DISPLAY: begin
        tmr_run = 1'b1;
        if (tmr_last) adv = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      state_n = S_FETCH;
      ph_n    = 1'b0;
      if (plane == PBITS'(DEPTH - 1)) begin
        plane_n = '0;
        row_n   = row + ROW_BITS'(1);
        if (row == '1) state_n = S_IDLE;
      end else begin
        plane_n = plane + PBITS'(1);
      end
    end
  end

  // Outputs are registered from the next-state view so each pin is valid for
  // the whole cycle of the state it belongs to.
  always_comb begin
    rd_n   = ((state_n == S_FETCH) && !ph_n) ||
             ((state_n == S_SHIFT) && !ph_n && (col_n != CBITS'(COLS - 1)));
    addr_n = (state_n == S_FETCH) ? {row_n, CBITS'(0)} : {row_n, col_n + CBITS'(1)};
    ck_n   = (state_n == S_SHIFT) && ph_n;
    st_n   = (state_n == S_LATCH);
    oe_n   = (state_n != S_DISPLAY);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      row         <= '0;
      plane       <= '0;
      col         <= '0;
      ph          <= 1'b0;
      bcnt        <= '0;
      bright_q    <= '0;
      rd_q        <= 1'b0;
      ram_rd      <= 1'b0;
      ram_addr    <= '0;
      hub_rgb     <= '0;
      hub_row     <= '0;
      hub_ck      <= 1'b0;
      hub_st      <= 1'b0;
      hub_oe      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      row         <= row_n;
      plane       <= plane_n;
      col         <= col_n;
      ph          <= ph_n;
      bcnt        <= bcnt_n;
      rd_q        <= ram_rd;
      ram_rd      <= rd_n;
      hub_ck      <= ck_n;
      hub_st      <= st_n;
      hub_oe      <= oe_n;
      frame_start <= start;
      if (start)               bright_q <= brightness;
      if (rd_n)                ram_addr <= addr_n;
      if (rd_q)                hub_rgb  <= rgb_n;
      if (state_n == S_LATCH)  hub_row  <= row_n;
    end
  end

endmodule
